// File: rtl/mux2to1_arbiter.sv
// Round-robin arbiter sharing one 2:1 data mux between two level-sensitive requesters.
// Optional build macro ARB_TIMEOUT_EN: forced hand-over after HOLD_MAX cycles under contention.
module mux2to1_arbiter #(
  parameter int W        = 1,
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         gnt0,
  output logic         gnt1,
  output logic         s,
  output logic [W-1:0] m,
  output logic         busy,
  output logic         preempt,
  output logic [1:0]   dbg_state
);

  // Handshake: a requester holds reqN high for as long as it wants the channel;
  // gntN is asserted from the edge after the request is accepted until the edge
  // after reqN drops (or a forced hand-over). There is no back-pressure on m.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   last, last_nxt;
  logic   timeout_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = last ? GNT0 : GNT1;
        else if (req0)    state_nxt = GNT0;
        else if (req1)    state_nxt = GNT1;
      end
      GNT0: begin
        if (!req0)                     state_nxt = req1 ? GNT1 : IDLE;
        else if (req1 && timeout_hit)  state_nxt = GNT1;
      end
      GNT1: begin
        if (!req1)                     state_nxt = req0 ? GNT0 : IDLE;
        else if (req0 && timeout_hit)  state_nxt = GNT0;
      end
      default: state_nxt = IDLE;
    endcase
    if (state_nxt == GNT0 && state != GNT0) last_nxt = 1'b0;
    if (state_nxt == GNT1 && state != GNT1) last_nxt = 1'b1;
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] count;
  logic             preempt_q;
  logic             preempt_nxt;

  assign timeout_hit = (count == HOLD_LAST);
  // Both requests high with the owner at its limit is exactly the forced hand-over case.
  assign preempt_nxt = timeout_hit && req0 && req1 && (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= preempt_nxt;
      if (state_nxt != IDLE && state_nxt != state) count <= '0;
      else if (state != IDLE && count != HOLD_LAST) count <= count + 1'b1;
    end
  end

  assign preempt = preempt_q;
`else
  assign timeout_hit = 1'b0;
  assign preempt     = 1'b0;
`endif

  assign gnt0      = (state == GNT0);
  assign gnt1      = (state == GNT1);
  assign s         = (state == GNT1);
  assign busy      = (state == GNT0) || (state == GNT1);
  assign m         = s ? y : x;
  assign dbg_state = state;

endmodule

// File: tb/tb_mux2to1_arbiter.sv
// Directed + randomized bench for mux2to1_arbiter against an ownership-level reference model.
module tb_mux2to1_arbiter;
  localparam int W        = 4;
  localparam int HOLD_MAX = 8;
  localparam int CNT_W    = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [W-1:0] x, y;
  logic         gnt0, gnt1, s, busy, preempt;
  logic [W-1:0] m;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the channel (-1 none), who was served last,
  // how many cycles the current owner has held it, and the preempt pulse.
  int  own;
  int  last_own;
  int  held;
  bit  pre;

  mux2to1_arbiter #(.W(W), .HOLD_MAX(HOLD_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .x(x), .y(y),
    .gnt0(gnt0), .gnt1(gnt1), .s(s), .m(m), .busy(busy),
    .preempt(preempt), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit mine, other, timeout_on;
`ifdef ARB_TIMEOUT_EN
    timeout_on = 1'b1;
`else
    timeout_on = 1'b0;
`endif
    pre = 1'b0;
    if (rst) begin
      own = -1; last_own = 1; held = 0;
    end else if (own == -1) begin
      if (req0 && req1)  own = (last_own == 1) ? 0 : 1;
      else if (req0)     own = 0;
      else if (req1)     own = 1;
      if (own != -1) begin last_own = own; held = 1; end
    end else begin
      mine  = (own == 0) ? req0 : req1;
      other = (own == 0) ? req1 : req0;
      if (!mine) begin
        if (other) begin own = 1 - own; last_own = own; held = 1; end
        else own = -1;
      end else if (timeout_on && other && held >= HOLD_MAX) begin
        own = 1 - own; last_own = own; held = 1; pre = 1'b1;
      end else if (held < 1000) begin
        held++;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".gnt0"},    gnt0,    (own == 0));
    check({tag, ".gnt1"},    gnt1,    (own == 1));
    check({tag, ".s"},       s,       (own == 1));
    check({tag, ".busy"},    busy,    (own != -1));
    check({tag, ".preempt"}, preempt, pre);
    check({tag, ".m"},       m,       (own == 1) ? y : x);
  endtask

  // One clock: inputs already applied; advance model on the edge, sample 1 time unit later.
  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  task automatic drive(input logic r, input logic r0, input logic r1);
    rst = r; req0 = r0; req1 = r1;
  endtask

  initial begin
    own = -1; last_own = 1; held = 0; pre = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    x = W'($urandom); y = W'($urandom);

    // Reset, nobody requesting
    cycle("reset0");
    cycle("reset1");

    // Lone requester 1
    drive(1'b0, 1'b0, 1'b0); x = 1; y = 0;
    cycle("idle");
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle("lone_req1");
    drive(1'b0, 1'b0, 1'b0);
    cycle("release_req1");
    cycle("idle_after_release");

    // Tie after reset, then back-to-back hand-over, then tie from IDLE
    drive(1'b1, 1'b0, 1'b0); cycle("reset_tie");
    drive(1'b0, 1'b1, 1'b1); x = W'($urandom); y = W'($urandom);
    cycle("tie_first");
    cycle("tie_hold");
    drive(1'b0, 1'b0, 1'b1);
    cycle("handover_no_gap");
    drive(1'b0, 1'b0, 1'b0);
    cycle("to_idle");
    drive(1'b0, 1'b1, 1'b1);
    cycle("tie_again");
    drive(1'b0, 1'b0, 1'b0);
    cycle("drop_all");

    // Reset in the middle of a grant to requester 1
    drive(1'b0, 1'b0, 1'b1);
    cycle("grant1_pre_reset");
    cycle("grant1_pre_reset2");
    drive(1'b1, 1'b0, 1'b1);
    cycle("reset_mid_grant");
    drive(1'b0, 1'b1, 1'b1);
    cycle("tie_after_reset");
    drive(1'b0, 1'b0, 1'b0);
    cycle("drop_all2");

    // Contention with req0 held: forced hand-over only in the timeout build
    drive(1'b1, 1'b0, 1'b0); cycle("reset_contend");
    drive(1'b0, 1'b1, 1'b0);
    cycle("req0_alone");
    drive(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 100; i++) begin
      x = W'($urandom); y = W'($urandom);
      cycle("contend");
    end
    drive(1'b0, 1'b0, 1'b1);
    cycle("req0_drops");
    drive(1'b0, 1'b0, 1'b0);
    cycle("drop_all3");

    // Randomized traffic with biased long holds and occasional reset
    for (int i = 0; i < 400; i++) begin
      rst  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) == 0) req0 = ~req0;
      if ($urandom_range(0, 3) == 0) req1 = ~req1;
      x = W'($urandom); y = W'($urandom);
      cycle("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end
endmodule
